key_sideload_serializer: RTL and testbench
==========================================

// Module: key_sideload_serializer
// PURPOSE
//  Captures a multi-share sideload key (Shares x KeyWidth, packed share-major) in one beat.
//  Streams it out as WordWidth-bit words over a valid/ready interface.
//  Sits between the key manager sideload port and a word-wide consumer (cipher key regs, CSR shadow).
//  Optional unmask mode XORs all shares per word. Buffer is wiped after every stream or on clear.
// PARAMETERS
//  Shares     2   number of key shares (>=1)
//  KeyWidth   64  bits per share; must be a multiple of WordWidth (elaboration $error otherwise)
//  WordWidth  32  output word width
//  Unmask     0   0: emit every share's words; 1: emit XOR of all shares, one word per index
//  (derived) NumWords = KeyWidth/WordWidth
//  (derived) IdxW = max(1,$clog2(NumWords)), ShW = max(1,$clog2(Shares))
// PORTS
//  clk_i         in   1                     clock, all logic on rising edge
//  rst_i         in   1                     synchronous reset, active-high
//  key_valid_i   in   1                     key_i valid
//  key_ready_o   out  1                     block idle, accepts key
//  key_i         in   Shares*KeyWidth       packed [Shares-1:0][KeyWidth-1:0] key
//  clear_i       in   1                     abort current stream and wipe buffer
//  word_valid_o  out  1                     word_data_o valid
//  word_ready_i  in   1                     consumer accepts word
//  word_data_o   out  WordWidth             current word
//  word_share_o  out  ShW                   share of current word (0 when Unmask=1)
//  word_idx_o    out  IdxW                  word index within share
//  word_last_o   out  1                     current word is final of stream
//  done_o        out  1                     one-cycle pulse after final word handshake
// BEHAVIOUR
//  Reset: state=IDLE, buffer=0, counters=0; word_valid_o/word_last_o/done_o=0. word_data_o=0.
//   key_ready_o=1 from the first cycle after reset deasserts.
//  FSM IDLE -> STREAM -> WIPE -> IDLE.
//  IDLE: key_ready_o=1. On key_valid_i, capture key_i into buffer, clear sh/idx, go STREAM.
//   key_valid_i with clear_i in the same cycle: clear wins, no capture, stay IDLE.
//  STREAM: word_valid_o=1, key_ready_o=0; key_valid_i ignored.
//   Word = buf[sh][idx*WordWidth +: WordWidth]. In Unmask mode, word = XOR over s of buf[s][idx*WordWidth +: WordWidth].
//  Latency: capture at edge N -> word_valid_o=1 in the cycle after edge N.
//   Sustained ready gives one word per cycle.
//  Order: idx increments first (0..NumWords-1), then sh (0..Shares-1). Unmask: sh stays 0.
//  Data/share/idx/last are held stable while valid && !ready (no drop, no change).
//  word_last_o = (idx==NumWords-1) && (Unmask || sh==Shares-1).
//  Handshake on a last word -> WIPE. done_o pulses in the WIPE cycle.
//  WIPE (1 cycle): buffer and counters zeroed, word_valid_o=0 -> IDLE.
//  clear_i in STREAM: next state WIPE, word_valid_o drops next cycle, no done_o.
//   A handshake in the same cycle as clear_i still completes.
//  word_data_o=0 whenever word_valid_o=0, so key bits never show outside STREAM.
//  rst_i mid-stream: immediate return to reset values; buffer zeroed.
//  Total beats per key: Shares*NumWords (Unmask=0) or NumWords (Unmask=1).
// TESTING (defaults unless noted; share0=64'h0123456789abcdef, share1=64'hfedcba9876543210)
//  1. Load, ready held 1 -> words 89abcdef,01234567,76543210,fedcba98.
//     (share,idx) = (0,0),(0,1),(1,0),(1,1); last on 4th beat; done_o the next cycle; key_ready_o back 1 after WIPE.
//  2. Unmask=1, same key -> two words ffffffff,ffffffff; word_share_o=0; last on 2nd beat.
//  3. Random ready stalls (ready=0 for 3 cycles mid-word) -> data/idx held stable, sequence identical to test 1.
//  4. clear_i after 1st handshake -> no further valid, no done_o.
//     Next key load streams from (0,0); internal buffer reads 0 in WIPE.
//  5. key_valid_i pulsed during STREAM with a different key -> ignored; original words emitted.
//  6. rst_i asserted on 2nd word -> all outputs reset values next cycle.
//     Params Shares=3,KeyWidth=128,WordWidth=32 -> 12 beats in correct order.

Source files
------------

// File: rtl/key_sideload_serializer.sv
// -----------------------------------------------------------------------------
// key_sideload_serializer
//
// Captures a multi-share sideload key (Shares x KeyWidth, packed share-major)
// in a single beat and streams it out as WordWidth-bit words over a
// valid/ready interface. With Unmask=1 the shares are XOR-combined and one
// word per index is emitted. The key buffer is wiped after every stream and
// on clear, so key material never lingers once a stream has ended.
//
// Ports:
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous reset, active-high
//   key_valid_i   key_i valid
//   key_ready_o   block idle, accepts a key
//   key_i         packed [Shares-1:0][KeyWidth-1:0] key
//   clear_i       abort the current stream and wipe the buffer
//   word_valid_o  word_data_o valid
//   word_ready_i  consumer accepts the word
//   word_data_o   current word (0 whenever word_valid_o is low)
//   word_share_o  share of the current word (0 when Unmask=1)
//   word_idx_o    word index within the share
//   word_last_o   current word is the final one of the stream
//   done_o        one-cycle pulse after the final word handshake
// -----------------------------------------------------------------------------
module key_sideload_serializer #(
    parameter int Shares    = 2,
    parameter int KeyWidth  = 64,
    parameter int WordWidth = 32,
    parameter int Unmask    = 0,
    localparam int NumWords = KeyWidth / WordWidth,
    localparam int IdxW     = (NumWords > 1) ? $clog2(NumWords) : 1,
    localparam int ShW      = (Shares > 1) ? $clog2(Shares) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         key_valid_i,
    output logic                         key_ready_o,
    input  logic [Shares*KeyWidth-1:0]   key_i,
    input  logic                         clear_i,
    output logic                         word_valid_o,
    input  logic                         word_ready_i,
    output logic [WordWidth-1:0]         word_data_o,
    output logic [ShW-1:0]               word_share_o,
    output logic [IdxW-1:0]              word_idx_o,
    output logic                         word_last_o,
    output logic                         done_o
);

    if (KeyWidth % WordWidth != 0) begin : g_bad_key_width
        $error("KeyWidth must be a multiple of WordWidth");
    end
    if (Shares < 1) begin : g_bad_shares
        $error("Shares must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WIPE
    } state_e;

    localparam logic [IdxW-1:0] IdxLast = IdxW'(NumWords - 1);
    localparam logic [ShW-1:0]  ShLast  = ShW'(Shares - 1);

    state_e                          state;
    logic [Shares-1:0][KeyWidth-1:0] key_buf;
    logic [ShW-1:0]                  sh;
    logic [IdxW-1:0]                 idx;
    logic                            done_q;

    logic                 last_word;
    logic                 handshake;
    logic [WordWidth-1:0] word_mux;

    // In unmask mode the share counter never advances, so the last word is
    // simply the last index.
    assign last_word = (idx == IdxLast) && ((Unmask != 0) || (sh == ShLast));
    assign handshake = (state == ST_STREAM) && word_ready_i;

    // NOTE: every variable assigned in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        word_mux = '0;
        if (Unmask != 0) begin
            for (int s = 0; s < Shares; s++) begin
                word_mux = word_mux ^ key_buf[s][idx*WordWidth +: WordWidth];
            end
        end else begin
            word_mux = key_buf[sh][idx*WordWidth +: WordWidth];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its inputs from before the clock edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            // NOTE: the key buffer is deliberately reset; it holds secret
            // material and must read zero after reset, unlike a plain
            // datapath memory that would be left unreset.
            key_buf <= '0;
            sh      <= '0;
            idx     <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // clear_i takes priority over a simultaneous key offer.
                    if (key_valid_i && !clear_i) begin
                        key_buf <= key_i;
                        sh      <= '0;
                        idx     <= '0;
                        state   <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (clear_i || (handshake && last_word)) begin
                        // Wipe on entry to WIPE so the buffer already reads
                        // zero during the WIPE cycle.
                        key_buf <= '0;
                        sh      <= '0;
                        idx     <= '0;
                        done_q  <= !clear_i;
                        state   <= ST_WIPE;
                    end else if (handshake) begin
                        if (idx == IdxLast) begin
                            idx <= '0;
                            sh  <= sh + 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                ST_WIPE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign key_ready_o  = (state == ST_IDLE);
    assign word_valid_o = (state == ST_STREAM);
    assign word_data_o  = word_valid_o ? word_mux : '0;
    assign word_share_o = (Unmask != 0) ? '0 : sh;
    assign word_idx_o   = idx;
    assign word_last_o  = word_valid_o && last_word;
    assign done_o       = done_q;

endmodule

// File: tb/tb_key_sideload_serializer.sv
// -----------------------------------------------------------------------------
// tb_key_sideload_serializer
//
// Drives three instances in lockstep from shared control inputs:
//   dut_a : Shares=2, KeyWidth=64,  WordWidth=32, Unmask=0
//   dut_u : Shares=2, KeyWidth=64,  WordWidth=32, Unmask=1
//   dut_c : Shares=3, KeyWidth=128, WordWidth=32, Unmask=0
// dut_a/dut_u see the low 128 bits of the stimulus key, dut_c sees all 384.
// A negedge monitor records accepted words and checks hold/idle/done rules;
// scenario tasks compare the recorded words with a reference model that
// derives the expected word list directly from the key layout.
// -----------------------------------------------------------------------------
module tb_key_sideload_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         key_valid;
    logic         clear;
    logic         word_ready;
    logic [383:0] stim_key;

    logic        a_krdy, a_vld, a_last, a_done;
    logic [31:0] a_dat;
    logic [0:0]  a_sh, a_idx;
    logic        u_krdy, u_vld, u_last, u_done;
    logic [31:0] u_dat;
    logic [0:0]  u_sh, u_idx;
    logic        c_krdy, c_vld, c_last, c_done;
    logic [31:0] c_dat;
    logic [1:0]  c_sh, c_idx;

    key_sideload_serializer #(.Shares(2), .KeyWidth(64), .WordWidth(32), .Unmask(0)) dut_a (
        .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_ready_o(a_krdy),
        .key_i(stim_key[127:0]), .clear_i(clear), .word_valid_o(a_vld),
        .word_ready_i(word_ready), .word_data_o(a_dat), .word_share_o(a_sh),
        .word_idx_o(a_idx), .word_last_o(a_last), .done_o(a_done)
    );

    key_sideload_serializer #(.Shares(2), .KeyWidth(64), .WordWidth(32), .Unmask(1)) dut_u (
        .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_ready_o(u_krdy),
        .key_i(stim_key[127:0]), .clear_i(clear), .word_valid_o(u_vld),
        .word_ready_i(word_ready), .word_data_o(u_dat), .word_share_o(u_sh),
        .word_idx_o(u_idx), .word_last_o(u_last), .done_o(u_done)
    );

    key_sideload_serializer #(.Shares(3), .KeyWidth(128), .WordWidth(32), .Unmask(0)) dut_c (
        .clk_i(clk), .rst_i(rst), .key_valid_i(key_valid), .key_ready_o(c_krdy),
        .key_i(stim_key), .clear_i(clear), .word_valid_o(c_vld),
        .word_ready_i(word_ready), .word_data_o(c_dat), .word_share_o(c_sh),
        .word_idx_o(c_idx), .word_last_o(c_last), .done_o(c_done)
    );

    // Per-instance views, indexed 0=a, 1=u, 2=c.
    logic [2:0]  krdy, vld, lst, dn;
    logic [31:0] dat  [3];
    logic [1:0]  shr  [3];
    logic [1:0]  idxo [3];
    assign krdy = {c_krdy, u_krdy, a_krdy};
    assign vld  = {c_vld, u_vld, a_vld};
    assign lst  = {c_last, u_last, a_last};
    assign dn   = {c_done, u_done, a_done};
    assign dat[0] = a_dat;
    assign dat[1] = u_dat;
    assign dat[2] = c_dat;
    assign shr[0] = {1'b0, a_sh};
    assign shr[1] = {1'b0, u_sh};
    assign shr[2] = c_sh;
    assign idxo[0] = {1'b0, a_idx};
    assign idxo[1] = {1'b0, u_idx};
    assign idxo[2] = c_idx;

    typedef struct {
        logic [31:0] data;
        int          share;
        int          idx;
        bit          last;
    } beat_t;

    int           vectors = 0;
    int           errors  = 0;
    beat_t        got [3][$];
    int           done_cnt [3];
    logic [383:0] model_key;
    bit           mon_en = 1'b0;

    // ---------------- reference model ----------------
    function automatic int m_shares(int d);
        return (d == 2) ? 3 : 2;
    endfunction

    function automatic int m_kw(int d);
        return (d == 2) ? 128 : 64;
    endfunction

    function automatic int m_beats(int d);
        if (d == 1) return m_kw(d) / 32;
        return m_shares(d) * (m_kw(d) / 32);
    endfunction

    // Word k of the stream: share-major, index-minor; unmask XORs all shares.
    function automatic beat_t exp_beat(int d, int k);
        beat_t b;
        int    kw = m_kw(d);
        int    nw = kw / 32;
        int    s;
        int    i;
        if (d == 1) begin
            i      = k;
            b.data = '0;
            for (int sh = 0; sh < m_shares(d); sh++) begin
                b.data = b.data ^ model_key[sh*kw + i*32 +: 32];
            end
            b.share = 0;
        end else begin
            s       = k / nw;
            i       = k % nw;
            b.data  = model_key[s*kw + i*32 +: 32];
            b.share = s;
        end
        b.idx  = i;
        b.last = (k == m_beats(d) - 1);
        return b;
    endfunction

    function automatic logic [383:0] rand_key();
        logic [383:0] k;
        for (int i = 0; i < 12; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    // ---------------- monitor ----------------
    logic        p_rst, p_clr, p_rdy;
    logic [2:0]  p_vld, p_lst, p_hsl;
    logic [31:0] p_dat [3];
    logic [1:0]  p_sh  [3];
    logic [1:0]  p_ix  [3];

    always @(negedge clk) begin
        if (mon_en) begin
            for (int d = 0; d < 3; d++) begin
                if (!vld[d]) begin
                    vectors++;
                    if (dat[d] !== '0) begin
                        errors++;
                        $display("FAIL idle_data dut%0d: got %h, want 0", d, dat[d]);
                    end
                end
                if (p_vld[d] && !p_rdy && !p_rst && !p_clr) begin
                    vectors++;
                    if (vld[d] !== 1'b1 || dat[d] !== p_dat[d] || shr[d] !== p_sh[d] ||
                        idxo[d] !== p_ix[d] || lst[d] !== p_lst[d]) begin
                        errors++;
                        $display("FAIL hold dut%0d: got v=%b d=%h s=%0d i=%0d l=%b, want v=1 d=%h s=%0d i=%0d l=%b",
                                 d, vld[d], dat[d], shr[d], idxo[d], lst[d], p_dat[d], p_sh[d], p_ix[d], p_lst[d]);
                    end
                end
                vectors++;
                if (dn[d] !== (p_hsl[d] && !p_rst && !p_clr)) begin
                    errors++;
                    $display("FAIL done_pulse dut%0d: got %b, want %b", d, dn[d], p_hsl[d] && !p_rst && !p_clr);
                end
                if (dn[d] === 1'b1) done_cnt[d]++;
                if (vld[d] && word_ready && !rst) begin
                    beat_t b;
                    b.data  = dat[d];
                    b.share = int'(shr[d]);
                    b.idx   = int'(idxo[d]);
                    b.last  = lst[d];
                    got[d].push_back(b);
                end
            end
        end
        p_rst = rst;
        p_clr = clear;
        p_rdy = word_ready;
        p_vld = vld;
        p_lst = lst;
        p_hsl = vld & lst & {3{word_ready}};
        for (int d = 0; d < 3; d++) begin
            p_dat[d] = dat[d];
            p_sh[d]  = shr[d];
            p_ix[d]  = idxo[d];
        end
    end

    // ---------------- stimulus helpers ----------------
    // Starts at posedge+1 with all instances idle; returns at posedge+1 with
    // the first word on the bus.
    task automatic load(input logic [383:0] k);
        for (int d = 0; d < 3; d++) begin
            got[d].delete();
            done_cnt[d] = 0;
        end
        model_key = k;
        stim_key  = k;
        key_valid = 1'b1;
        @(posedge clk); #1;
        key_valid = 1'b0;
        vectors++;
        if (vld !== 3'b111 || krdy !== 3'b000) begin
            errors++;
            $display("FAIL load_latency: got valid=%b ready=%b, want valid=111 ready=000", vld, krdy);
        end
    endtask

    // Streams the loaded key to completion and compares against the model.
    // stall: random ready with a forced 3-cycle stall after the first word.
    // inject: offer a different key while streaming.
    task automatic test_stream_case(input string name, input bit stall, input bit inject);
        int    cyc = 0;
        beat_t e;
        while (!(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0) && cyc < 300) begin
            if (stall) word_ready = (cyc == 0) ? 1'b1 : (cyc <= 3) ? 1'b0 : 1'($urandom_range(0, 1));
            else       word_ready = 1'b1;
            if (inject && cyc == 1) begin
                key_valid = 1'b1;
                stim_key  = ~model_key;
            end else if (inject && cyc == 2) begin
                key_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        word_ready = 1'b0;
        key_valid  = 1'b0;
        vectors++;
        if (cyc >= 300) begin
            errors++;
            $display("FAIL %s timeout: done counts %0d/%0d/%0d, want all 1", name, done_cnt[0], done_cnt[1], done_cnt[2]);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (krdy !== 3'b111 || vld !== 3'b000) begin
            errors++;
            $display("FAIL %s idle_after: got ready=%b valid=%b, want 111/000", name, krdy, vld);
        end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (got[d].size() != m_beats(d) || done_cnt[d] != 1) begin
                errors++;
                $display("FAIL %s beat_count dut%0d: got %0d beats %0d dones, want %0d beats 1 done",
                         name, d, got[d].size(), done_cnt[d], m_beats(d));
            end else begin
                for (int k = 0; k < m_beats(d); k++) begin
                    e = exp_beat(d, k);
                    vectors++;
                    if (got[d][k].data !== e.data || got[d][k].share != e.share ||
                        got[d][k].idx != e.idx || got[d][k].last != e.last) begin
                        errors++;
                        $display("FAIL %s beat dut%0d #%0d: got %h s%0d i%0d l%0d, want %h s%0d i%0d l%0d",
                                 name, d, k, got[d][k].data, got[d][k].share, got[d][k].idx, got[d][k].last,
                                 e.data, e.share, e.idx, e.last);
                    end
                end
            end
        end
    endtask

    function automatic logic [383:0] fixed_key();
        logic [383:0] k;
        k = rand_key();
        k[63:0]   = 64'h0123456789abcdef;
        k[127:64] = 64'hfedcba9876543210;
        return k;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (vld !== 3'b000 || lst !== 3'b000 || dn !== 3'b000 || krdy !== 3'b111 ||
            dat[0] !== '0 || dat[1] !== '0 || dat[2] !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b l=%b d=%b r=%b, want 000/000/000/111", vld, lst, dn, krdy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (krdy !== 3'b111 || vld !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: got ready=%b valid=%b, want 111/000", krdy, vld);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        logic [31:0] want_a [4];
        int          want_s [4];
        int          want_i [4];
        want_a = '{32'h89abcdef, 32'h01234567, 32'h76543210, 32'hfedcba98};
        want_s = '{0, 0, 1, 1};
        want_i = '{0, 1, 0, 1};
        load(fixed_key());
        test_stream_case("basic", 1'b0, 1'b0);
        if (got[0].size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (got[0][k].data !== want_a[k] || got[0][k].share != want_s[k] ||
                    got[0][k].idx != want_i[k] || got[0][k].last != (k == 3)) begin
                    errors++;
                    $display("FAIL basic_const #%0d: got %h s%0d i%0d, want %h s%0d i%0d",
                             k, got[0][k].data, got[0][k].share, got[0][k].idx, want_a[k], want_s[k], want_i[k]);
                end
            end
        end
        if (got[1].size() == 2) begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (got[1][k].data !== 32'hffffffff || got[1][k].share != 0 || got[1][k].last != (k == 1)) begin
                    errors++;
                    $display("FAIL unmask_const #%0d: got %h s%0d l%0d, want ffffffff s0 l%0d",
                             k, got[1][k].data, got[1][k].share, got[1][k].last, k == 1);
                end
            end
        end
    endtask

    task automatic test_stall();
        for (int r = 0; r < 4; r++) begin
            load((r == 0) ? fixed_key() : rand_key());
            test_stream_case("stall", 1'b1, 1'b0);
        end
    endtask

    task automatic test_clear();
        load(rand_key());
        word_ready = 1'b1;
        @(posedge clk); #1;
        word_ready = 1'b0;
        clear      = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        vectors++;
        if (vld !== 3'b000 || dn !== 3'b000 || dut_a.key_buf !== '0 || dut_c.key_buf !== '0) begin
            errors++;
            $display("FAIL clear_wipe: got valid=%b done=%b, want 000/000 and zero buffers", vld, dn);
        end
        repeat (3) begin
            @(posedge clk); #1;
            vectors++;
            if (vld !== 3'b000) begin
                errors++;
                $display("FAIL clear_no_valid: got %b, want 000", vld);
            end
        end
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (got[d].size() != 1 || done_cnt[d] != 0 || got[d][0].data !== exp_beat(d, 0).data) begin
                errors++;
                $display("FAIL clear_beats dut%0d: got %0d beats %0d dones, want 1 beat 0 dones", d, got[d].size(), done_cnt[d]);
            end
        end
        load(rand_key());
        test_stream_case("after_clear", 1'b0, 1'b0);
    endtask

    task automatic test_ignore_key();
        for (int r = 0; r < 2; r++) begin
            load(rand_key());
            test_stream_case("ignore_key", 1'b0, 1'b1);
        end
    endtask

    task automatic test_midstream_reset();
        load(rand_key());
        word_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (vld !== 3'b000 || lst !== 3'b000 || dn !== 3'b000 || krdy !== 3'b111 ||
            dat[2] !== '0 || shr[2] !== 2'd0 || idxo[2] !== 2'd0 ||
            dut_a.key_buf !== '0 || dut_c.key_buf !== '0) begin
            errors++;
            $display("FAIL midstream_reset: got v=%b l=%b d=%b r=%b, want 000/000/000/111 and zero state",
                     vld, lst, dn, krdy);
        end
        rst        = 1'b0;
        word_ready = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            vectors++;
            if (got[d].size() != 1 || done_cnt[d] != 0) begin
                errors++;
                $display("FAIL reset_beats dut%0d: got %0d beats %0d dones, want 1/0", d, got[d].size(), done_cnt[d]);
            end
        end
        load(rand_key());
        test_stream_case("after_reset", 1'b0, 1'b0);
    endtask

    initial begin
        rst        = 1'b1;
        key_valid  = 1'b0;
        clear      = 1'b0;
        word_ready = 1'b0;
        stim_key   = '0;
        model_key  = '0;
        for (int d = 0; d < 3; d++) done_cnt[d] = 0;
        test_reset();
        test_basic();
        test_stall();
        test_clear();
        test_ignore_key();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
